// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with a one-entry skid buffer: in_ready depends only on registered
// state. The stall counter saturates and only rst clears it.
module id_ex_skid_reg #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ALUOP_W = 3,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ALUOP_W-1:0] alu_op_in,
   input  logic               reg_dst_in,
   input  logic [DATA_W-1:0]  data1_in,
   input  logic [DATA_W-1:0]  data2_in,
   input  logic [RADDR_W-1:0] rs_in,
   input  logic [RADDR_W-1:0] rt_in,
   input  logic [RADDR_W-1:0] rd_in,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ALUOP_W-1:0] alu_op_out,
   output logic [DATA_W-1:0]  data1_out,
   output logic [DATA_W-1:0]  data2_out,
   output logic [RADDR_W-1:0] rs_out,
   output logic [RADDR_W-1:0] rt_out,
   output logic [RADDR_W-1:0] dest_out,
   output logic [CNT_W-1:0]   stall_cnt
);

   localparam int unsigned PAY_W = ALUOP_W + 2 * DATA_W + 3 * RADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [PAY_W-1:0]   in_pay;
   logic [PAY_W-1:0]   out_pay_q, out_pay_d;
   logic [PAY_W-1:0]   skid_pay_q, skid_pay_d;
   logic               out_valid_q, out_valid_d;
   logic               skid_valid_q, skid_valid_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [RADDR_W-1:0] dest;
   logic               accept;
   logic               drain;

   // Destination is resolved here so EX never sees reg_dst.
   assign dest     = reg_dst_in ? rd_in : rt_in;
   assign in_pay   = {alu_op_in, data1_in, data2_in, rs_in, rt_in, dest};
   assign in_ready = ~skid_valid_q;
   assign accept   = in_valid & in_ready;
   assign drain    = out_valid_q & out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      out_pay_d    = out_pay_q;
      skid_pay_d   = skid_pay_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
         out_pay_d    = '0;
         skid_pay_d   = '0;
      end else if (skid_valid_q) begin
         if (drain) begin
            out_pay_d    = skid_pay_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end
      end else if (!out_valid_q || drain) begin
         out_valid_d = accept;
         if (accept) begin
            out_pay_d = in_pay;
         end
      end else if (accept) begin
         skid_pay_d   = in_pay;
         skid_valid_d = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_pay_q    <= '0;
         skid_pay_q   <= '0;
         stall_cnt_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         out_pay_q    <= out_pay_d;
         skid_pay_q   <= skid_pay_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign stall_cnt = stall_cnt_q;
   assign {alu_op_out, data1_out, data2_out, rs_out, rt_out, dest_out} = out_pay_q;

endmodule

// File: doc/id_ex_skid_reg.md
ID_EX_SKID_REG -- requirements
Module: id_ex_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of each register-operand word.
REQ-002 Parameter ALUOP_W, default 3, width of the ALU operation code.
REQ-003 Parameter RADDR_W, default 5, width of register-number fields.
REQ-004 Parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-005 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 in_valid  input  1  ID stage presents a valid instruction.
REQ-009 in_ready  output  1  stage can accept; equals NOT skid_valid (registered state only, no combinational path from out_ready).
REQ-010 alu_op_in  input  ALUOP_W  ALU operation code.
REQ-011 reg_dst_in  input  1  destination select: 1 = rd, 0 = rt.
REQ-012 data1_in, data2_in  input  DATA_W each  register-file read values.
REQ-013 rs_in, rt_in, rd_in  input  RADDR_W each  instruction register fields.
REQ-014 flush  input  1  synchronous squash of all held instructions.
REQ-015 out_valid  output  1  EX-stage payload valid.
REQ-016 out_ready  input  1  EX stage accepts payload this cycle.
REQ-017 alu_op_out, data1_out, data2_out, rs_out, rt_out  output  widths as inputs  registered payload.
REQ-018 dest_out  output  RADDR_W  registered write destination.
REQ-019 stall_cnt  output  CNT_W  saturating count of stalled cycles.

Function
REQ-020 Accept = in_valid AND in_ready; drain = out_valid AND out_ready; both evaluated at the rising edge.
REQ-021 Capture SHALL compute dest = reg_dst_in ? rd_in : rt_in and store it; reg_dst is not propagated.
REQ-022 Two storage slots: output register (out_*) and skid register (skid_valid + payload).
REQ-023 skid_valid=0, out_valid=0 or drain, accept: input payload -> output register, out_valid=1; latency 1 cycle.
REQ-024 skid_valid=0, out_valid=0 or drain, no accept: out_valid -> 0, payload outputs hold previous values.
REQ-025 skid_valid=0, out_valid=1, no drain, accept: input payload -> skid register, skid_valid=1; output unchanged.
REQ-026 skid_valid=1, drain: skid payload -> output register, out_valid=1, skid_valid=0 (no accept possible since in_ready=0).
REQ-027 skid_valid=1, no drain: all state holds.
REQ-028 Ordering SHALL be strict FIFO; no instruction duplicated or dropped except by flush.
REQ-029 flush=1: next edge out_valid=0, skid_valid=0, all payload outputs and skid payload =0; a same-cycle accept is discarded; flush overrides drain and accept.
REQ-030 stall_cnt increments by 1 each edge with out_valid=1 AND out_ready=0, saturates at 2^CNT_W-1, unaffected by flush, cleared only by rst.
REQ-031 Backpressure: out_ready low with out_valid high SHALL hold every out_* stable.

Reset
REQ-032 rst=1 SHALL immediately (asynchronously) clear out_valid, skid_valid, all payload outputs, skid payload and stall_cnt to 0; in_ready reads 1.
REQ-033 Reset asserted mid-transfer discards all held instructions; first accept after release behaves as REQ-023.

Verification
REQ-034 Stream: out_ready=1, three accepts data1_in=0x11,0x22,0x33 back-to-back -> out_valid=1 with data1_out 0x11,0x22,0x33 on cycles 1,2,3; stall_cnt=0.
REQ-035 Backpressure: out holds A (0xAAAA_0001), out_ready=0, accept B -> in_ready=0 next cycle, data1_out stays A, stall_cnt increments each cycle; out_ready=1 -> A drains, then B appears, then in_ready=1.
REQ-036 Dest select: reg_dst_in=1, rt_in=5, rd_in=9 -> dest_out=9; reg_dst_in=0 same fields -> dest_out=5.
REQ-037 Flush: out and skid both full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, data1_out=0, stall_cnt unchanged.
REQ-038 Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-039 Async reset: assert rst between edges with both slots full -> out_valid=0, stall_cnt=0, in_ready=1 before next clock edge.
